result_drain_ctrl: RTL and testbench
====================================

# result_drain_ctrl

Read-side controller for the systolic array's result SRAM. After a compute pass writes rows of PARTIAL_SUM_BW-wide lanes into the result SRAM, this block reads a programmed number of rows, starting at a base address. It returns them to the host over a valid/ready stream with backpressure. It sits between the result SRAM's read port and the host/DMA interface, and is the consumer of the rows the array's result path produces.

## Interface

Parameters:
- ADDRESSSIZE, 10, result SRAM address width
- MATRIX_SIZE, 16, lanes per row; also the maximum rows per transfer
- PARTIAL_SUM_BW, 24, bits per lane (signed)
- CNT_W, 5, row-count width; equals $clog2(MATRIX_SIZE)+1

Ports:
- clk  in  1  sole clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; honoured only in IDLE
- base_addr  in  ADDRESSSIZE  first row address; sampled on an accepted start
- num_rows  in  CNT_W  rows to drain; sampled on an accepted start
- sram_read_enable  out  1  read strobe to the result SRAM
- sram_address  out  ADDRESSSIZE  read address
- sram_data_in  in  PARTIAL_SUM_BW*MATRIX_SIZE  SRAM read data; valid exactly 1 cycle after the strobe
- m_valid  out  1  output row valid
- m_ready  in  1  host accepts the row
- m_data  out  PARTIAL_SUM_BW*MATRIX_SIZE  output row; lane i is at bits [i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]
- m_last  out  1  high with the final row of a transfer
- busy  out  1  high from an accepted start until done
- done  out  1  one-cycle pulse after the last handshake

## Operation

- State machine IDLE → READ → DRAIN → IDLE.
  - IDLE: a start with num_rows in 1..MATRIX_SIZE latches the base address and the count, then goes to READ.
  - A start with num_rows = 0 issues no reads and pulses done in the next cycle.
  - num_rows > MATRIX_SIZE is clamped to MATRIX_SIZE.
- READ:
  - Issue one read per cycle while credit is available.
  - Credit condition: buffer occupancy + reads in flight − (m_valid & m_ready) < 2.
  - The address increments by 1 per issued read and wraps modulo 2^ADDRESSSIZE.
  - Move to DRAIN in the cycle after the last read is issued.
- DRAIN: wait until the buffer is empty and the final row has completed its handshake. Then pulse done and return to IDLE.
- Data buffer:
  - Two-entry FIFO captures sram_data_in in the cycle after each strobe.
  - m_valid means the FIFO is not empty; m_data is the FIFO head.
  - Overflow cannot occur by construction; the credit rule guarantees it.
- m_valid and m_data hold stable while m_valid=1 and m_ready=0.
- m_last is asserted when the head row is row num_rows−1 of the transfer.
- A start while busy is ignored; the latched values are unchanged.
- rst at any point:
  - returns the block to IDLE and clears the FIFO, counters and credits;
  - discards an in-flight read return;
  - produces no done pulse.

## Timing

- Reset values: sram_read_enable=0, sram_address=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
- start accepted in cycle 0:
  - busy=1 in cycle 1;
  - first sram_read_enable with sram_address=base_addr in cycle 1;
  - data returns in cycle 2;
  - m_valid=1 in cycle 3.
- With m_ready held high, throughput is one row per cycle. N rows finish their handshakes in cycles 3..N+2, and done pulses in cycle N+3 with busy=0 in the same cycle.
- With m_ready low, at most 2 reads are outstanding or buffered. Reads pause, with sram_read_enable=0, until a handshake frees credit.
- A new start is accepted in the cycle after done at the earliest.

## Configuration

- RESULT_DRAIN_RELU_EN:
  - Defined: each lane of m_data is clamped at zero, so negative signed PARTIAL_SUM_BW values are output as 0 and non-negative values pass unchanged. The clamp is combinational on the FIFO head and adds no latency.
  - Undefined: lanes pass through bit-exact.

## Test plan

- Reset, then start with base_addr=0 and num_rows=16, m_ready=1 → addresses 0..15 are strobed in cycles 1..16, rows appear in cycles 3..18, m_last is set on row 15, and done pulses in cycle 19.
- base_addr=1022, num_rows=4 → addresses 1022, 1023, 0, 1 in that order; output data matches the SRAM model.
- num_rows=8 with m_ready toggled in a 0,0,1 pattern → no sram_read_enable while 2 rows are buffered or in flight. All 8 rows arrive in order, none dropped or duplicated, and m_data stays stable while stalled.
- Start while busy with different base_addr/num_rows → ignored; the original transfer completes unchanged. num_rows=0 → done in the next cycle with no reads.
- Assert rst in the cycle a read returns, mid-transfer → all outputs take their reset values in the next cycle, with no done pulse. A fresh start afterwards behaves normally.
- With RESULT_DRAIN_RELU_EN defined, a row with lane 0 = −5 and lane 1 = 7 → the output has lane 0 = 0 and lane 1 = 7. Without the macro, lane 0 = 24'hFFFFFB.

Source files
------------

// File: rtl/result_drain_ctrl.sv
// result_drain_ctrl
// Drains a programmed number of rows from the result SRAM and streams them
// to the host over a valid/ready interface with backpressure.
// Optional build macro: RESULT_DRAIN_RELU_EN (clamps negative lanes to zero).
//
// Handshake: a row transfers on every rising edge where m_valid && m_ready.
// Once m_valid rises it stays high, with m_data/m_last stable, until that
// transfer happens; m_valid never depends on m_ready.

module result_drain_ctrl #(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 16,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int CNT_W          = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic [CNT_W-1:0]                      num_rows,
    output logic                                  sram_read_enable,
    output logic [ADDRESSSIZE-1:0]                sram_address,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_data_in,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] m_data,
    output logic                                  m_last,
    output logic                                  busy,
    output logic                                  done,
    output logic [1:0]                            dbg_state
);

    localparam int ROW_W = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam logic [CNT_W-1:0] MAX_ROWS = CNT_W'(MATRIX_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDRESSSIZE-1:0] addr_q;
    logic [CNT_W-1:0]       num_q;
    logic [CNT_W-1:0]       rd_cnt;
    logic [CNT_W-1:0]       hs_cnt;
    logic                   rd_pending;
    logic [ROW_W-1:0]       fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_cnt;
    logic [ROW_W-1:0]       head;

    logic             accept;
    logic             accept_go;
    logic [CNT_W-1:0] num_clamped;
    logic             handshake;
    logic [2:0]       in_use;
    logic             credit_ok;
    logic             rd_en;
    logic             last_issue;
    logic             last_hs;

    // start is only taken in IDLE, and never in the cycle done is pulsing
    assign accept      = start && (state == IDLE) && !done;
    assign num_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    assign accept_go   = accept && (num_clamped != '0);
    assign handshake   = m_valid && m_ready;

    // rows buffered plus rows in flight, less the row leaving this cycle
    assign in_use     = {1'b0, fifo_cnt} + {2'b00, rd_pending};
    assign credit_ok  = (in_use - {2'b00, handshake}) < 3'd2;
    assign rd_en      = (state == READ) && (rd_cnt != num_q) && credit_ok;
    assign last_issue = rd_en && (rd_cnt == num_q - CNT_W'(1));
    assign last_hs    = handshake && m_last;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_go)  state_nxt = READ;
            READ:    if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (last_hs)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        sram_read_enable = rd_en;
        busy             = (state != IDLE);
        dbg_state        = state;
    end

    // transfer bookkeeping: latched request, read/handshake counters, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            num_q      <= '0;
            rd_cnt     <= '0;
            hs_cnt     <= '0;
            rd_pending <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_pending <= rd_en;
            done       <= (accept && (num_clamped == '0)) || ((state == DRAIN) && last_hs);
            if (accept_go) begin
                addr_q <= base_addr;
                num_q  <= num_clamped;
                rd_cnt <= '0;
                hs_cnt <= '0;
            end else begin
                if (rd_en) begin
                    addr_q <= addr_q + ADDRESSSIZE'(1);
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
                if (handshake) hs_cnt <= hs_cnt + CNT_W'(1);
            end
        end
    end

    // two-entry FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (rd_pending) wr_ptr <= ~wr_ptr;
            if (handshake)  rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, rd_pending} - {1'b0, handshake};
        end
    end

    // FIFO storage captures the SRAM return one cycle after each strobe
    always_ff @(posedge clk) begin
        if (rd_pending) fifo_mem[wr_ptr] <= sram_data_in;
    end

    assign sram_address = addr_q;
    assign m_valid      = (fifo_cnt != 2'd0);
    assign head         = fifo_mem[rd_ptr];
    assign m_last       = m_valid && (hs_cnt == num_q - CNT_W'(1));

    // output row: FIFO head (optionally ReLU-clamped per lane), zero when empty
    always_comb begin
        logic [PARTIAL_SUM_BW-1:0] lane;
        m_data = '0;
        lane   = '0;
        if (m_valid) begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                lane = head[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
`ifdef RESULT_DRAIN_RELU_EN
                if (lane[PARTIAL_SUM_BW-1]) lane = '0;
`else
                lane = lane;
`endif
                m_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = lane;
            end
        end
    end

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Testbench for result_drain_ctrl: SRAM model, transfer-level reference
// model (expected address/row queues) and a handshake scoreboard.
module tb_result_drain_ctrl;

    localparam int AW    = 10;
    localparam int MS    = 16;
    localparam int PSB   = 24;
    localparam int CW    = 5;
    localparam int ROW_W = PSB * MS;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [CW-1:0]    num_rows = '0;
    logic             sram_read_enable;
    logic [AW-1:0]    sram_address;
    logic [ROW_W-1:0] sram_data_in = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [ROW_W-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    logic [ROW_W-1:0] mem [DEPTH];
    logic [AW-1:0]    addr_q [$];
    logic [ROW_W-1:0] exp_q [$];
    logic             last_q [$];
    int               ready_mode = 0;
    int               reads_total = 0;
    int               hs_total = 0;

    result_drain_ctrl #(
        .ADDRESSSIZE(AW), .MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .sram_read_enable(sram_read_enable),
        .sram_address(sram_address), .sram_data_in(sram_data_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (sram_read_enable) sram_data_in <= mem[sram_address];
    end

    // host ready driver
    always @(posedge clk) begin
        static int pat = 0;
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                m_ready = (pat == 2);
                pat = (pat + 1) % 3;
            end
        endcase
    end

    // reference: a row as the host should see it
    function automatic logic [ROW_W-1:0] model_row(input logic [ROW_W-1:0] r);
        logic [ROW_W-1:0] o;
        o = r;
`ifdef RESULT_DRAIN_RELU_EN
        for (int i = 0; i < MS; i++)
            if ($signed(r[i*PSB +: PSB]) < 0) o[i*PSB +: PSB] = '0;
`endif
        return o;
    endfunction

    // reference: expected reads and rows of one accepted transfer
    task automatic push_expect(input int base, input int n);
        int nn;
        nn = (n > MS) ? MS : n;
        for (int i = 0; i < nn; i++) begin
            addr_q.push_back(AW'((base + i) % DEPTH));
            exp_q.push_back(model_row(mem[(base + i) % DEPTH]));
            last_q.push_back(i == nn - 1);
        end
    endtask

    // scoreboard: read order, credit bound, row data/last, stall stability
    always @(negedge clk) begin
        static logic             prev_stall = 1'b0;
        static logic [ROW_W-1:0] prev_data = '0;
        if (rst) begin
            addr_q.delete(); exp_q.delete(); last_q.delete();
            reads_total = 0; hs_total = 0; prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_valid || m_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%0b data=%h required data=%h", m_valid, m_data, prev_data);
                end
            end
            if (sram_read_enable) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_addr: unexpected read of %0d, required none", sram_address);
                end else begin
                    if (sram_address !== addr_q[0]) begin
                        errors++;
                        $display("FAIL read_addr: got %0d required %0d", sram_address, addr_q[0]);
                    end
                    void'(addr_q.pop_front());
                end
                checks++;
                if (reads_total - hs_total - int'(m_valid && m_ready) >= 2) begin
                    errors++;
                    $display("FAIL credit: read with %0d outstanding, required < 2",
                             reads_total - hs_total - int'(m_valid && m_ready));
                end
                reads_total++;
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL row: unexpected row %h, required none", m_data);
                end else begin
                    if (m_data !== exp_q[0] || m_last !== last_q[0]) begin
                        errors++;
                        $display("FAIL row: got data=%h last=%0b required data=%h last=%0b",
                                 m_data, m_last, exp_q[0], last_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(last_q.pop_front());
                end
                hs_total++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // wait (bounded) for done; leaves the bench at the negedge of the done cycle
    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // drive a start in the current cycle, then advance to cycle 1
    task automatic drive_start(input int base, input int n);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'(base);
        num_rows = CW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sram_read_enable, sram_address, m_valid, m_data, m_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_values: en=%0b addr=%0d valid=%0b last=%0b busy=%0b done=%0b, required all 0",
                     sram_read_enable, sram_address, m_valid, m_last, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_burst();
        ready_mode = 0;
        push_expect(0, 16);
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0; num_rows = CW'(16);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (sram_read_enable !== (k >= 1 && k <= 16) || m_valid !== (k >= 3 && k <= 18) ||
                m_last !== (k == 18) || done !== (k == 19) || busy !== (k >= 1 && k <= 18)) begin
                errors++;
                $display("FAIL full_burst_timing: cycle %0d en=%0b valid=%0b last=%0b done=%0b busy=%0b",
                         k, sram_read_enable, m_valid, m_last, done, busy);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_burst_rows: %0d rows left, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        bit seen;
        ready_mode = 0;
        push_expect(1022, 4);
        drive_start(1022, 4);
        wait_done(50, seen);
        checks++;
        if (!seen || addr_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap: done=%0b reads_left=%0d rows_left=%0d, required 1/0/0", seen, addr_q.size(), exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        int hs0;
        ready_mode = 2;
        hs0 = hs_total;
        push_expect($urandom_range(0, DEPTH - 1), 8);
        drive_start(addr_q[0], 8);
        wait_done(100, seen);
        checks++;
        if (!seen || hs_total - hs0 != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure: done=%0b rows=%0d, required 1/8", seen, hs_total - hs0);
        end
        ready_mode = 0;
    endtask

    task automatic test_busy_start();
        bit seen;
        int b;
        ready_mode = 1;
        b = $urandom_range(0, DEPTH - 1);
        push_expect(b, 6);
        drive_start(b, 6);
        start = 1'b1; base_addr = AW'(b + 100); num_rows = CW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, seen);
        checks++;
        if (!seen || addr_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL busy_start: done=%0b reads_left=%0d rows_left=%0d, required 1/0/0", seen, addr_q.size(), exp_q.size());
        end
        ready_mode = 0;
    endtask

    task automatic test_zero_rows();
        drive_start(37, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sram_read_enable !== 1'b0) begin
            errors++;
            $display("FAIL zero_rows: done=%0b busy=%0b en=%0b, required 1/0/0", done, busy, sram_read_enable);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sram_read_enable !== 1'b0) begin
            errors++;
            $display("FAIL zero_rows_after: done=%0b en=%0b, required 0/0", done, sram_read_enable);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int b;
        ready_mode = 0;
        b = $urandom_range(0, DEPTH - 1);
        push_expect(b, 10);
        drive_start(b, 10);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;              // cycle 5: the read issued in cycle 4 returns
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({sram_read_enable, sram_address, m_valid, m_data, m_last, busy, done} !== '0) begin
                errors++;
                $display("FAIL reset_mid: t=%0d en=%0b addr=%0d valid=%0b last=%0b busy=%0b done=%0b, required all 0",
                         k, sram_read_enable, sram_address, m_valid, m_last, busy, done);
            end
            @(posedge clk); #1;
        end
        b = $urandom_range(0, DEPTH - 1);
        push_expect(b, 3);
        drive_start(b, 3);
        wait_done(50, seen);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_restart: done=%0b rows_left=%0d, required 1/0", seen, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit seen;
        int b, n;
        for (int t = 0; t < 8; t++) begin
            ready_mode = $urandom_range(0, 2);
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 20);
            push_expect(b, n);
            drive_start(b, n);
            wait_done(200, seen);
            checks++;
            if (!seen || busy !== 1'b0 || exp_q.size() != 0 || addr_q.size() != 0) begin
                errors++;
                $display("FAIL random: t=%0d n=%0d done=%0b busy=%0b rows_left=%0d, required 1/0/0",
                         t, n, seen, busy, exp_q.size());
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_relu();
        bit seen;
        logic [ROW_W-1:0] r;
        logic [PSB-1:0]   exp0;
        r = mem[500];
        r[0 +: PSB]   = PSB'(-5);
        r[PSB +: PSB] = PSB'(7);
        mem[500] = r;
`ifdef RESULT_DRAIN_RELU_EN
        exp0 = '0;
`else
        exp0 = 24'hFFFFFB;
`endif
        push_expect(500, 1);
        drive_start(500, 1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1'b1;
                checks++;
                if (m_data[0 +: PSB] !== exp0 || m_data[PSB +: PSB] !== PSB'(7)) begin
                    errors++;
                    $display("FAIL relu_lanes: lane0=%h lane1=%h required %h/%h",
                             m_data[0 +: PSB], m_data[PSB +: PSB], exp0, PSB'(7));
                end
            end
            if (!seen) begin
                @(posedge clk); #1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL relu_valid: no row within budget");
        end
        wait_done(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL relu_done: done=0 required 1");
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++)
            for (int w = 0; w < ROW_W / 32; w++)
                mem[a][w*32 +: 32] = $urandom;
        test_reset();
        test_full_burst();
        test_wrap();
        test_backpressure();
        test_busy_start();
        test_zero_rows();
        test_reset_mid();
        test_random();
        test_relu();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
